// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   APB initiator. Takes one read/write command at a time on a valid/ready
//   command port. For each command it runs an APB SETUP -> ACCESS transfer,
//   waits out PREADY wait states, and returns the read data and PSLVERR status
//   on a valid/ready response port. A new command is only accepted after the
//   previous response has been taken, so one transfer at most is outstanding.
//
// Optional build macro:
//   APB_MASTER_TIMEOUT_EN - abandon an ACCESS phase after TIMEOUT_CYCLES wait
//                           states and report it as an error response.
//
// Ports:
//   iPCLK, iPRESET            clock; synchronous active-high reset
//   iCMD_VALID/oCMD_READY     command handshake (ready only in IDLE)
//   iCMD_WRITE/ADDR/WDATA     command direction, byte address, write data
//   oRSP_VALID/iRSP_READY     response handshake
//   oRSP_RDATA, oRSP_ERR      read data (0 for writes), slave error/timeout
//   oPSEL..oPWDATA            APB request outputs, all registered
//   iPRDATA/iPREADY/iPSLVERR  APB completion inputs

module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  iPCLK,
    input  logic                  iPRESET,
    input  logic                  iCMD_VALID,
    output logic                  oCMD_READY,
    input  logic                  iCMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] iCMD_ADDR,
    input  logic [DATA_WIDTH-1:0] iCMD_WDATA,
    output logic                  oRSP_VALID,
    input  logic                  iRSP_READY,
    output logic [DATA_WIDTH-1:0] oRSP_RDATA,
    output logic                  oRSP_ERR,
    output logic                  oPSEL,
    output logic                  oPENABLE,
    output logic                  oPWRITE,
    output logic [ADDR_WIDTH-1:0] oPADDR,
    output logic [DATA_WIDTH-1:0] oPWDATA,
    input  logic [DATA_WIDTH-1:0] iPRDATA,
    input  logic                  iPREADY,
    input  logic                  iPSLVERR
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    // Clear the two byte-offset bits so the bus only sees word addresses.
    localparam logic [ADDR_WIDTH-1:0] AlignMask = ~(ADDR_WIDTH'(3));

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntWidth-1:0] tcnt_q, tcnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
        tcnt_d      = tcnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (iCMD_VALID) begin
                    pwrite_d  = iCMD_WRITE;
                    paddr_d   = iCMD_ADDR & AlignMask;
                    pwdata_d  = iCMD_WDATA;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
`ifdef APB_MASTER_TIMEOUT_EN
                tcnt_d    = '0;
`endif
            end
            StAccess: begin
                // PREADY wins over a timeout reached in the same cycle.
                if (iPREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : iPRDATA;
                    rsp_err_d   = iPSLVERR;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // This wait state is the one that brings the count to the limit.
                else if (tcnt_q == CntWidth'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                if (iRSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iPCLK) begin
        if (iPRESET) begin
            state_q     <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    assign oCMD_READY = (state_q == StIdle);
    assign oRSP_VALID = rsp_valid_q;
    assign oRSP_RDATA = rsp_rdata_q;
    assign oRSP_ERR   = rsp_err_q;
    assign oPSEL      = psel_q;
    assign oPENABLE   = penable_q;
    assign oPWRITE    = pwrite_q;
    assign oPADDR     = paddr_q;
    assign oPWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Directed, table-driven bench for apb_master_bridge. Each table record is
//   one complete transfer: the command, the slave's behaviour (wait states,
//   read data, error) and the response back-pressure, plus the expected
//   address and response. Hand-written sequences cover back-to-back commands,
//   reset during a wait state and (when built with the macro) the timeout.

module tb_apb_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .iPCLK      (clk),
        .iPRESET    (rst),
        .iCMD_VALID (cmd_valid),
        .oCMD_READY (cmd_ready),
        .iCMD_WRITE (cmd_write),
        .iCMD_ADDR  (cmd_addr),
        .iCMD_WDATA (cmd_wdata),
        .oRSP_VALID (rsp_valid),
        .iRSP_READY (rsp_ready),
        .oRSP_RDATA (rsp_rdata),
        .oRSP_ERR   (rsp_err),
        .oPSEL      (psel),
        .oPENABLE   (penable),
        .oPWRITE    (pwrite),
        .oPADDR     (paddr),
        .oPWDATA    (pwdata),
        .iPRDATA    (prdata),
        .iPREADY    (pready),
        .iPSLVERR   (pslverr)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            stall;
        logic [AW-1:0] exp_paddr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        sample();
        chk({tag, ".cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        step();                                   // edge N: command accepted
        cmd_valid = 1'b0;
        cmd_wdata = 32'h0BAD_0BAD;
        sample();                                 // SETUP cycle
        chk({tag, ".setup_psel"}, 64'(psel), 64'd1);
        chk({tag, ".setup_penable"}, 64'(penable), 64'd0);
        chk({tag, ".paddr"}, 64'(paddr), 64'(v.exp_paddr));
        chk({tag, ".pwrite"}, 64'(pwrite), 64'(v.write));
        chk({tag, ".pwdata"}, 64'(pwdata), 64'(v.wdata));
        chk({tag, ".cmd_ready_busy"}, 64'(cmd_ready), 64'd0);
        for (int i = 0; i <= v.waits; i++) begin
            step();
            if (i == v.waits) begin
                pready  = 1'b1;
                prdata  = v.prdata;
                pslverr = v.slverr;
            end else begin
                // Junk on the data/error lines during waits must be ignored.
                pready  = 1'b0;
                prdata  = 32'hFFFF_FFFF;
                pslverr = 1'b1;
            end
            sample();
            chk({tag, ".access_ctl"}, {61'd0, psel, penable, rsp_valid}, 64'b110);
            chk({tag, ".access_addr"}, 64'(paddr), 64'(v.exp_paddr));
            chk({tag, ".access_wdata"}, 64'(pwdata), 64'(v.wdata));
        end
        step();
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h7777_7777;
        for (int i = 0; i <= v.stall; i++) begin
            rsp_ready = (i == v.stall);
            sample();
            chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
            chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
            chk({tag, ".resp_ctl"}, {61'd0, psel, penable, cmd_ready}, 64'b000);
            step();
        end
        rsp_ready = 1'b0;
        sample();
        chk({tag, ".rsp_done"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".ready_again"}, 64'(cmd_ready), 64'd1);
        chk({tag, ".paddr_kept"}, 64'(paddr), 64'(v.exp_paddr));
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_00F0, 0, 32'h1111_1111, 1'b0, 0,
                    32'h0000_0004, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 3, 32'hA5A5_0F0F, 1'b0, 0,
                    32'h0000_0000, 32'hA5A5_0F0F, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0000_0033, 0, 32'h0000_1234, 1'b1, 4,
                    32'h0000_0010, 32'h0000_1234, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_000E, 32'hDEAD_BEEF, 1, 32'h5555_5555, 1'b0, 1,
                    32'h0000_000C, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0103, 32'h0000_0000, 0, 32'hCAFE_F00D, 1'b0, 0,
                    32'h0000_0100, 32'hCAFE_F00D, 1'b0};

        step();
        step();
        rst = 1'b0;
        sample();
        chk("reset.ctl", {57'd0, psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready, 1'b0},
            64'b0000010);
        chk("reset.paddr", 64'(paddr), 64'd0);
        chk("reset.pwdata", 64'(pwdata), 64'd0);
        chk("reset.rdata", 64'(rsp_rdata), 64'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back: valid held high through RESP; second SETUP only after
        // the first response handshake.
        step();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0020;
        cmd_wdata = 32'h0000_0001;
        pready    = 1'b1;
        step();                                   // accept #1
        cmd_addr  = 32'h0000_0027;
        cmd_wdata = 32'h0000_0002;
        step();                                   // ACCESS
        step();                                   // RESP
        pready = 1'b0;
        sample();
        chk("b2b.resp_valid", 64'(rsp_valid), 64'd1);
        chk("b2b.resp_ready_low", 64'(cmd_ready), 64'd0);
        step();
        sample();
        chk("b2b.no_second_setup", {62'd0, psel, penable}, 64'd0);
        chk("b2b.addr_first", 64'(paddr), 64'h20);
        rsp_ready = 1'b1;
        step();                                   // back in IDLE
        rsp_ready = 1'b0;
        sample();
        chk("b2b.idle_ready", 64'(cmd_ready), 64'd1);
        chk("b2b.idle_psel", 64'(psel), 64'd0);
        step();                                   // accept #2
        cmd_valid = 1'b0;
        sample();
        chk("b2b.second_setup", {62'd0, psel, penable}, 64'b10);
        chk("b2b.second_addr", 64'(paddr), 64'h24);
        chk("b2b.second_wdata", 64'(pwdata), 64'h2);
        pready    = 1'b1;
        rsp_ready = 1'b1;
        seen      = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            sample();
            if (rsp_valid) seen = 1'b1;
        end
        chk("b2b.second_rsp_seen", 64'(seen), 64'd1);
        step();
        pready    = 1'b0;
        rsp_ready = 1'b0;

        // Reset during an ACCESS wait state.
        step();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0008;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        sample();
        chk("rst_mid.in_wait", {62'd0, psel, penable}, 64'b11);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        chk("rst_mid.ctl", {61'd0, psel, penable, rsp_valid}, 64'd0);
        chk("rst_mid.cmd_ready", 64'(cmd_ready), 64'd1);

`ifdef APB_MASTER_TIMEOUT_EN
        // Timeout with PREADY stuck low: 8 wait states, then an error response.
        step();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0040;
        prdata    = 32'hFFFF_FFFF;
        step();
        cmd_valid = 1'b0;
        step();                                   // first ACCESS cycle
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("tmo.waiting", {61'd0, psel, penable, rsp_valid}, 64'b110);
            step();
        end
        sample();
        chk("tmo.rsp_valid", 64'(rsp_valid), 64'd1);
        chk("tmo.rsp_err", 64'(rsp_err), 64'd1);
        chk("tmo.rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("tmo.psel", {62'd0, psel, penable}, 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        sample();
        chk("tmo.idle", 64'(cmd_ready), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
